// File: rtl/mine_ann_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mine_ann_pkg
//  Description : Shared types, default widths and the fixed Q4.4 weight and
//                bias tables for the sequenced mine-detection network.
//  Revision    : 1.0 - initial release
// ============================================================================
package mine_ann_pkg;

  localparam int N_HID = 4;   // hidden neurons; output fan-in
  localparam int N_IN  = 4;   // sensor switches
  localparam int N_OUT = 2;   // indicator neurons
  localparam int W_W   = 8;   // weight/bias width, signed Q4.4
  localparam int ACC_W = 12;  // accumulator width, signed

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_HIDDEN = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef logic signed [W_W-1:0] coef_t;

  // Hidden neuron j passes sensor j straight through: weight +1.0 on its own
  // input, bias -0.5, so it fires exactly when that switch is set.
  localparam coef_t W_H [N_HID][N_IN] = '{
    '{8'sh10, 8'sh00, 8'sh00, 8'sh00},
    '{8'sh00, 8'sh10, 8'sh00, 8'sh00},
    '{8'sh00, 8'sh00, 8'sh10, 8'sh00},
    '{8'sh00, 8'sh00, 8'sh00, 8'sh10}
  };
  localparam coef_t B_H [N_HID] = '{8'shF8, 8'shF8, 8'shF8, 8'shF8};

  // Output 0 fires on any active hidden neuron (OR, bias -0.5);
  // output 1 needs all four active (AND, bias -3.5).
  localparam coef_t W_O [N_OUT][N_HID] = '{
    '{8'sh10, 8'sh10, 8'sh10, 8'sh10},
    '{8'sh10, 8'sh10, 8'sh10, 8'sh10}
  };
  localparam coef_t B_O [N_OUT] = '{8'shF8, 8'shC8};

endpackage
`default_nettype wire

// File: rtl/mine_ann_sequencer_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ann_gated_acc
//  Description : Shared gated-accumulate step. Either loads the sign-extended
//                bias or adds the sign-extended weight when the gate input is
//                set. Purely combinational; the caller owns the register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ann_gated_acc #(
  parameter int W_W   = 8,
  parameter int ACC_W = 12
) (
  input  logic                    load,
  input  logic                    en,
  input  logic signed [W_W-1:0]   bias,
  input  logic signed [W_W-1:0]   weight,
  input  logic                    gate,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_next,
  output logic                    sign
);

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] weight_ext;

  assign bias_ext   = {{(ACC_W-W_W){bias[W_W-1]}}, bias};
  assign weight_ext = {{(ACC_W-W_W){weight[W_W-1]}}, weight};

  // Bias load starts a neuron; otherwise a gated add stands in for x*w.
  always_comb begin
    acc_next = acc;
    if (en) begin
      if (load)
        acc_next = bias_ext;
      else if (gate)
        acc_next = acc + weight_ext;
    end
  end

  assign sign = acc_next[ACC_W-1];

endmodule
`default_nettype wire

// File: rtl/mine_ann_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mine_ann_sequencer
//  Description : Time-multiplexed evaluation controller. Latches the four
//                switches on start, walks every hidden then output neuron
//                through one shared gated accumulator, and presents the two
//                indicator results with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
import mine_ann_pkg::*;

module mine_ann_sequencer #(
  parameter int N_HID = mine_ann_pkg::N_HID,
  parameter int W_W   = mine_ann_pkg::W_W,
  parameter int ACC_W = mine_ann_pkg::ACC_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic switch_1,
  input  logic switch_2,
  input  logic switch_3,
  input  logic switch_4,
  output logic busy,
  output logic done,
  output logic indikator_1,
  output logic indikator_2
);

  localparam int MAX_FAN = (N_HID > N_IN) ? N_HID : N_IN;
  localparam int IDX_W   = $clog2(MAX_FAN);
  localparam int TERM_W  = $clog2(MAX_FAN + 1);
  // Term 0 is the bias cycle, so the last term index equals the fan-in.
  localparam logic [TERM_W-1:0] LAST_TERM_H = TERM_W'(N_IN);
  localparam logic [TERM_W-1:0] LAST_TERM_O = TERM_W'(N_HID);
  localparam logic [IDX_W-1:0]  LAST_HID    = IDX_W'(N_HID - 1);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        neuron;
  logic [TERM_W-1:0]       term;
  logic [IDX_W-1:0]        sel;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [N_IN-1:0]         x;
  logic [N_HID-1:0]        h;
  logic [N_OUT-1:0]        y;
  logic                    load, en, gate, last, layer_end, sign, act;
  logic signed [W_W-1:0]   bias, weight;

  // Input/weight column for the current term (term 1 addresses column 0).
  assign sel = IDX_W'(term - 1'b1);
  // Strict sign test: a sum of exactly zero counts as active.
  assign act = ~sign;

  ann_gated_acc #(
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .load     (load),
    .en       (en),
    .bias     (bias),
    .weight   (weight),
    .gate     (gate),
    .acc      (acc),
    .acc_next (acc_next),
    .sign     (sign)
  );

  // Next state plus per-cycle operand selection for the shared accumulator.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    en         = 1'b0;
    bias       = '0;
    weight     = '0;
    gate       = 1'b0;
    last       = 1'b0;
    layer_end  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_LATCH;
      S_LATCH: state_next = S_HIDDEN;
      S_HIDDEN: begin
        en        = 1'b1;
        load      = (term == '0);
        bias      = B_H[neuron];
        weight    = W_H[neuron][sel];
        gate      = x[sel];
        last      = (term == LAST_TERM_H);
        layer_end = last && (neuron == LAST_HID);
        if (layer_end) state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        en        = 1'b1;
        load      = (term == '0);
        bias      = B_O[neuron[0]];
        weight    = W_O[neuron[0]][sel];
        gate      = h[sel];
        last      = (term == LAST_TERM_O);
        layer_end = last && neuron[0];
        if (layer_end) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neuron      <= '0;
      term        <= '0;
      acc         <= '0;
      x           <= '0;
      h           <= '0;
      y           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      indikator_1 <= 1'b0;
      indikator_2 <= 1'b0;
    end else begin
      acc <= acc_next;
      if (state == S_LATCH)
        x <= {switch_4, switch_3, switch_2, switch_1};
      if (en) begin
        if (last) begin
          term   <= '0;
          neuron <= layer_end ? '0 : neuron + 1'b1;
        end else begin
          term <= term + 1'b1;
        end
      end
      if (state == S_HIDDEN && last) h[neuron]    <= act;
      if (state == S_OUTPUT && last) y[neuron[0]] <= act;
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      // Entering DONE coincides with the final output term, so output 1
      // is taken straight from the accumulator rather than from y.
      if (state_next == S_DONE) begin
        indikator_1 <= y[0];
        indikator_2 <= act;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mine_ann_sequencer.md
# mine_ann_sequencer

Time-multiplexed evaluation controller for the mine-detection network. It latches the four sensor switches on a start request and drives one shared gated-accumulate unit through every hidden neuron and then both output neurons. It registers the two indicator results and signals completion. It sits between the switch inputs and the board LEDs and replaces the per-neuron combinational datapath with one sequenced resource.

## Interface
- N_HID, 4: hidden-layer neuron count; output-layer fan-in equals N_HID.
- W_W, 8: weight/bias width, signed Q4.4.
- ACC_W, 12: accumulator width, signed.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  evaluation request; sampled only in IDLE.
- switch_1..switch_4  in  1 each  sensor inputs; values are 0/1.
- busy  out  1  high while an evaluation is in progress.
- done  out  1  one-cycle pulse when results are valid.
- indikator_1  out  1  output neuron 0 result; held until the next done.
- indikator_2  out  1  output neuron 1 result; held until the next done.

## Operation
- States: IDLE, LATCH, HIDDEN, OUTPUT, DONE.
- IDLE -> LATCH on start=1. LATCH copies switch_1..4 into the input register x[0..3]. Later switch changes do not affect the running evaluation.
- HIDDEN: for neuron j = 0..N_HID-1, spend 1 cycle loading the sign-extended bias b_h[j] into acc. Then spend 4 cycles adding w_h[j][i] for i = 0..3 when x[i]=1 (a gated add; there is no multiplier). On the last term, write h[j] = (acc_next >= 0).
- OUTPUT: the same scheme for k = 0..1, with a bias cycle plus N_HID term cycles over h[]. Write the output result register y[k] on the last term.
- DONE: copy y[0] to indikator_1 and y[1] to indikator_2, pulse done, then go to IDLE.
- Counters: a neuron index and a term index. The term index wraps to 0 at the end of each neuron. The neuron index wraps at the end of each layer.
- Arithmetic: all sums use ACC_W signed, two's complement. With default widths no overflow is possible (max |sum| = 5*128 < 2048). The activation is a strict sign test, so 0 counts as active.
- start while busy is ignored, with no queuing. start in the DONE cycle is also ignored.
- Reset at any time, including mid-evaluation: state=IDLE, counters=0, acc=0, x=0, h=0, y=0, busy=0, done=0, indikator_1=0, indikator_2=0.

## Timing
- Call the cycle in which start is sampled high in IDLE cycle 0.
- Cycle 1 is LATCH.
- Cycles 2 to 1+5*N_HID are HIDDEN.
- The next 2*(N_HID+1) cycles are OUTPUT.
- DONE follows at cycle L = 2 + 5*N_HID + 2*(N_HID+1) - 1 + 1, which is 32 for defaults.
- busy is registered: high in cycles 1..L, low from L+1.
- done is high only in cycle L. The indikators change in the same cycle as done.
- The earliest next accepted start is cycle L+1. Back-to-back throughput is one evaluation per L+1 cycles.

## Structure
- Package mine_ann_pkg holds:
  - the state enum;
  - W_W, ACC_W and N_HID defaults;
  - the weight/bias constant arrays W_H[N_HID][4], B_H[N_HID], W_O[2][N_HID] and B_O[2].
- Default constants:
  - W_H[j][i] = 0x10 (+1.0) if i==j, else 0; B_H = 0xF8 (-0.5).
  - W_O[0][*] = 0x10, B_O[0] = 0xF8, so output 0 is the OR of the hidden neurons.
  - W_O[1][*] = 0x10, B_O[1] = 0xC8 (-3.5), so output 1 is the AND of the hidden neurons.
- One sub-module, ann_gated_acc: inputs load, en, bias, weight, gate; outputs acc_next and sign. The controller owns acc and all sequencing.

## Test plan
- switch=0000, start pulse: done at cycle 32 -> indikator_1=0, indikator_2=0; busy high in cycles 1..32.
- switch=0001 (switch_4=1): done at cycle 32 -> indikator_1=1, indikator_2=0.
- switch=1111: indikator_1=1, indikator_2=1. Then switch=0110 with a new start at cycle 33: indikator_1=1, indikator_2=0 at cycle 65.
- Latch isolation: switch=0000 at start, then switch=1111 from cycle 3. Result must be 0,0. Extra start pulses in cycles 5 and 32 must be ignored, with no second done.
- Reset mid-run: rst_n low at cycle 15 after a prior 1,1 result. All outputs drop to 0 immediately. After release, start with switch=1000 gives 1,0 at 32 cycles after the new start.
